muldiv_unit: RTL and testbench

Multi-cycle RV32M multiply/divide unit beside the single-cycle ALU, fed with the same rs1/rs2 operands. It executes the eight M-extension operations. It holds the core stalled via `busy` until a one-cycle `done` pulse, then drives `result` into the write-back mux in place of the ALU output.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_div_core.sv | 45 ++++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiplier in muldiv_unit.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN    = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider: one quotient bit per enabled cycle. The next-step
// quotient/remainder are exported so the caller can capture the final step directly.
module muldiv_div_core
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quo_nxt,
   output logic [31:0] rem_nxt
);

   logic [31:0] quo, rem, dvsr, sub;
   logic [32:0] shifted;
   logic        ge;

   // Partial remainder stays below 2*divisor, so the 33-bit compare decides the bit
   // and a 32-bit difference is always exact when it is taken.
   always_comb begin
      shifted = {rem, quo[31]};
      ge      = shifted >= {1'b0, dvsr};
      sub     = shifted[31:0] - dvsr;
      rem_nxt = ge ? sub : shifted[31:0];
      quo_nxt = {quo[30:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo  <= '0;
         rem  <= '0;
         dvsr <= '0;
      end else if (load) begin
         quo  <= dividend;
         rem  <= '0;
         dvsr <= divisor;
      end else if (en) begin
         quo  <= quo_nxt;
         rem  <= rem_nxt;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, sign handling and multiplier around muldiv_div_core.
// Build option: `define MULDIV_FAST_MUL_EN for a one-cycle multiply (latency 2).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic        neg_q;
   logic [4:0]  cnt;
   logic [31:0] mcand;
   logic [63:0] acc;

   logic        a_sgn, b_sgn, is_div, div_zero, div_ovf, special, neg_at, accept, mul_last;
   logic [31:0] a_mag, b_mag, special_res, mul_res, div_res, quo_nxt, rem_nxt;
   logic [63:0] prod;

   // Operand decode at accept; signed operands become magnitudes.
   always_comb begin
      a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      a_mag    = (a_sgn && a[31]) ? -a : a;
      b_mag    = (b_sgn && b[31]) ? -b : b;
      is_div   = op[2];
      div_zero = is_div && (b == '0);
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == INT_MIN) && (b == 32'hFFFF_FFFF);
      special  = div_zero || div_ovf;
      neg_at   = (op == OP_REM) ? a[31] : ((a_sgn & a[31]) ^ (b_sgn & b[31]));
      if (div_zero) special_res = op[1] ? a : DIV_ZERO_Q;
      else          special_res = op[1] ? 32'd0 : INT_MIN;
      accept   = start && !kill && ((state == IDLE) || (state == DONE));
   end

`ifdef MULDIV_FAST_MUL_EN
   logic        a_ext, b_ext;
   logic [63:0] fa, fb;

   // Raw operands held in mcand/acc[31:0]; the extension bit makes it a 33x33 signed product.
   always_comb begin
      a_ext    = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && mcand[31];
      b_ext    = (op_q == OP_MULH) && acc[31];
      fa       = {{32{a_ext}}, mcand};
      fb       = {{32{b_ext}}, acc[31:0]};
      prod     = fa * fb;
      mul_last = 1'b1;
   end
`else
   logic [32:0] sum;
   logic [63:0] acc_nxt;

   // acc = {partial product, remaining multiplier bits}; shift right each step.
   always_comb begin
      sum      = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'd0)};
      acc_nxt  = {sum, acc[31:1]};
      prod     = neg_q ? -acc_nxt : acc_nxt;
      mul_last = (cnt == 5'd31);
   end
`endif

   always_comb begin
      mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];
      if (op_q[1]) div_res = neg_q ? -rem_nxt : rem_nxt;
      else         div_res = neg_q ? -quo_nxt : quo_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE, DONE: begin
            done      = (state == DONE);
            state_nxt = IDLE;
            if (accept) state_nxt = !is_div ? MUL : (special ? DONE : DIV);
         end
         MUL: begin
            busy = 1'b1;
            if (kill)          state_nxt = IDLE;
            else if (mul_last) state_nxt = DONE;
         end
         DIV: begin
            busy = 1'b1;
            if (kill)                state_nxt = IDLE;
            else if (cnt == 5'd31)   state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         neg_q  <= 1'b0;
         cnt    <= '0;
         mcand  <= '0;
         acc    <= '0;
         result <= '0;
      end else begin
         if (accept) begin
            op_q  <= op;
            neg_q <= neg_at;
            cnt   <= '0;
`ifdef MULDIV_FAST_MUL_EN
            mcand <= a;
            acc   <= {32'd0, b};
`else
            mcand <= a_mag;
            acc   <= {32'd0, b_mag};
`endif
            if (special) result <= special_res;
         end else if (state == MUL) begin
            cnt <= cnt + 5'd1;
`ifndef MULDIV_FAST_MUL_EN
            acc <= acc_nxt;
`endif
            if (!kill && mul_last) result <= mul_res;
         end else if (state == DIV) begin
            cnt <= cnt + 5'd1;
            if (!kill && (cnt == 5'd31)) result <= div_res;
         end
      end
   end

   muldiv_div_core u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept && is_div && !special),
      .en       (state == DIV),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_nxt  (quo_nxt),
      .rem_nxt  (rem_nxt)
   );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latencies, kill, reset and back-to-back issue.
module tb_muldiv_unit;
   import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst_n, start, kill;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] res;
   int          lat, bcnt, done_seen;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .kill   (kill),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after the accepting edge; k counts cycles after that edge.
   task automatic wait_done(input int inj, output logic [31:0] r, output int l, output int bc);
      l  = 0;
      bc = 0;
      r  = '0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == inj) begin
            op = OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
         end
         if (k == inj + 1) start = 1'b0;
         if (busy && done) check_eq("busy_done_excl", 32'd1, 32'd0);
         if (busy) bc++;
         if (done) begin
            l = k;
            r = result;
            break;
         end
      end
   endtask

   // Call at a negedge; start is sampled at the following posedge.
   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input int inj,
                        output logic [31:0] r, output int l, output int bc);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(inj, r, l, bc);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_result", result, 32'd0);

      do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bcnt);
      check_eq("div_m7_2", res, 32'hFFFF_FFFD);
      check_eq("div_lat", 32'(lat), 32'd33);
      check_eq("div_busy_cycles", 32'(bcnt), 32'd32);

      do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bcnt);
      check_eq("rem_m7_2", res, 32'hFFFF_FFFF);
      do_op(OP_REMU, 32'hFFFF_FFF9, 32'd2, 0, res, lat, bcnt);
      check_eq("remu_m7_2", res, 32'd1);

      do_op(OP_DIVU, 32'd5, 32'd0, 0, res, lat, bcnt);
      check_eq("divu_by0", res, 32'hFFFF_FFFF);
      check_eq("divu_by0_lat", 32'(lat), 32'd1);
      check_eq("divu_by0_busy", 32'(bcnt), 32'd0);
      do_op(OP_REM, 32'd5, 32'd0, 0, res, lat, bcnt);
      check_eq("rem_by0", res, 32'd5);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, bcnt);
      check_eq("div_ovf", res, 32'h8000_0000);
      check_eq("div_ovf_lat", 32'(lat), 32'd1);
      do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, lat, bcnt);
      check_eq("rem_ovf", res, 32'd0);

      do_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, 0, res, lat, bcnt);
      check_eq("mulh_min_min", res, 32'h4000_0000);
      check_eq("mul_lat", 32'(lat), 32'(MUL_LAT));
      check_eq("mul_busy_cycles", 32'(bcnt), 32'(MUL_LAT - 1));
      do_op(OP_MULHU, 32'h8000_0000, 32'h8000_0000, 0, res, lat, bcnt);
      check_eq("mulhu_min_min", res, 32'h4000_0000);
      do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt);
      check_eq("mulhsu_m1_max", res, 32'hFFFF_FFFF);
      check_eq("mulhsu_lat", 32'(lat), 32'(MUL_LAT));
      do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt);
      check_eq("mul_m1_m1", res, 32'd1);
      do_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, 0, res, lat, bcnt);
      check_eq("mulh_m2_3", res, 32'hFFFF_FFFF);

      do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, res, lat, bcnt);
      check_eq("div_7_m2", res, 32'hFFFF_FFFD);
      do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 0, res, lat, bcnt);
      check_eq("rem_7_m2", res, 32'd1);

      // A start pulsed mid-divide must not disturb the running operation.
      do_op(OP_DIV, 32'd100, 32'd7, 5, res, lat, bcnt);
      check_eq("ignore_start_res", res, 32'd14);
      check_eq("ignore_start_lat", 32'(lat), 32'd33);
      @(negedge clk);
      check_eq("idle_after_done", {31'd0, busy | done}, 32'd0);

      op = OP_DIV; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check_eq("kill_busy", {31'd0, busy}, 32'd0);
      check_eq("kill_done", {31'd0, done}, 32'd0);
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      check_eq("kill_no_done", 32'(done_seen), 32'd0);
      check_eq("kill_result_kept", result, 32'd14);

      op = OP_MUL; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_busy", {31'd0, busy}, 32'd0);
      check_eq("midrst_done", {31'd0, done}, 32'd0);
      check_eq("midrst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(OP_MUL, 32'd3, 32'd4, 0, res, lat, bcnt);
      check_eq("b2b_mul", res, 32'd12);
      check_eq("b2b_mul_lat", 32'(lat), 32'(MUL_LAT));
      do_op(OP_DIVU, 32'd12, 32'd4, 0, res, lat, bcnt);
      check_eq("b2b_divu", res, 32'd3);
      check_eq("b2b_divu_lat", 32'(lat), 32'd33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
